divide_seq: RTL and testbench

Parametrised sequential unsigned divider; successor of the fixed divide-by-10 block in the display path. It retires one quotient bit per clock using restoring shift-subtract, so latency is fixed and independent of operand value. The divisor is a runtime input. The block uses a proper start/busy/done handshake and flags divide-by-zero. It feeds the binary-to-BCD digit extraction ahead of the seven-segment multiplexer (divisor 10 in normal use).

---
 rtl/divide_pkg.sv | 16 +
 rtl/divide_step.sv | 27 ++
 rtl/divide_seq.sv | 127 ++++++++++++
 tb/tb_divide_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/divide_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// The FSM state type and the bit-counter sizing live here so the step and top stay consistent.
package divide_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Counter must hold DIVIDEND_W-1; a 1-bit dividend still needs one counter bit.
    function automatic int cnt_width(input int dividend_w);
        return (dividend_w > 1) ? $clog2(dividend_w) : 1;
    endfunction

endpackage

// File: rtl/divide_step.sv
// One restoring shift-subtract step: shifts a dividend bit into the partial remainder
// and trial-subtracts the divisor; the sign of the trial picks the quotient bit.
module divide_step
    import divide_pkg::*;
#(
    parameter int DIVISOR_W = 4
) (
    input  logic [DIVISOR_W-1:0] rem_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] rem_out,
    output logic                 q_bit
);

    logic [DIVISOR_W:0] shifted;
    logic [DIVISOR_W:0] trial;

    // rem_in is always below the divisor, so the shifted value is under twice the divisor
    // and the DIVISOR_W+1 bit trial difference never wraps into a false positive.
    always_comb begin
        shifted = {rem_in, bit_in};
        trial   = shifted - {1'b0, divisor};
        q_bit   = ~trial[DIVISOR_W];
        rem_out = q_bit ? trial[DIVISOR_W-1:0] : shifted[DIVISOR_W-1:0];
    end

endmodule

// File: rtl/divide_seq.sv
// Sequential unsigned divider, one quotient bit per clock, with start/busy/done handshake
// and divide-by-zero flag. Results are held in output registers until the next finish.
module divide_seq
    import divide_pkg::*;
#(
    parameter int DIVIDEND_W = 14,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int                CNT_W    = cnt_width(DIVIDEND_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIVIDEND_W - 1);

    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      cnt;
    logic                  zero_r;
    logic [DIVIDEND_W-1:0] shreg;
    logic [DIVISOR_W-1:0]  div_r;
    logic [DIVISOR_W-1:0]  rem_r;
    logic [DIVISOR_W-1:0]  rem_next;
    logic                  q_bit;
    logic                  accept;
    logic                  run;
    logic                  finish;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (divisor == '0) ? FINISH : RUN;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_next = FINISH;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        accept = (state == IDLE) && start;
        run    = (state == RUN);
        finish = (state == FINISH);
        busy   = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            zero_r <= 1'b0;
        end else if (accept) begin
            cnt    <= CNT_LAST;
            zero_r <= (divisor == '0);
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // The dividend shifts out MSB-first while quotient bits shift in at the LSB,
    // so after DIVIDEND_W steps the same register holds the quotient.
    always_ff @(posedge clk) begin
        if (accept) begin
            shreg <= dividend;
            div_r <= divisor;
            rem_r <= '0;
        end else if (run) begin
            shreg <= (shreg << 1) | DIVIDEND_W'(q_bit);
            rem_r <= rem_next;
        end
    end

    divide_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .rem_in  (rem_r),
        .bit_in  (shreg[DIVIDEND_W-1]),
        .divisor (div_r),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                if (zero_r) begin
                    quotient    <= '1;
                    remainder   <= '0;
                    div_by_zero <= 1'b1;
                end else begin
                    quotient    <= shreg;
                    remainder   <= rem_r;
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_divide_seq.sv
// Bench for divide_seq: two instances (14/4 and 8/8) checked every cycle against an
// arithmetic model of the handshake, plus directed literal cases.
module tb_divide_seq;

    localparam int W0 = 14;
    localparam int D0 = 4;
    localparam int W1 = 8;
    localparam int D1 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst0, start0, busy0, done0, dbz0;
    logic [W0-1:0] dvd0, quo0;
    logic [D0-1:0] dvs0, rem0;
    logic          rst1, start1, busy1, done1, dbz1;
    logic [W1-1:0] dvd1, quo1;
    logic [D1-1:0] dvs1, rem1;

    divide_seq #(.DIVIDEND_W(W0), .DIVISOR_W(D0)) u_dut0 (
        .clk(clk), .rst(rst0), .start(start0), .dividend(dvd0), .divisor(dvs0),
        .busy(busy0), .done(done0), .quotient(quo0), .remainder(rem0), .div_by_zero(dbz0)
    );

    divide_seq #(.DIVIDEND_W(W1), .DIVISOR_W(D1)) u_dut1 (
        .clk(clk), .rst(rst1), .start(start1), .dividend(dvd1), .divisor(dvs1),
        .busy(busy1), .done(done1), .quotient(quo1), .remainder(rem1), .div_by_zero(dbz1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an accepted request completes L cycles later with a/b, a%b.
    longint cyc = 0;
    bit     armed [2];
    bit     pend  [2];
    longint done_at [2];
    longint pq [2], pr [2];
    bit     pz [2];
    longint eq [2], er [2];
    bit     ez [2], eb [2], ed [2];

    task automatic model_step(input int k);
        bit r, s, b_, d_, z_;
        longint a, b, w, q_, rm;
        if (k == 0) begin
            r = rst0; s = start0; a = longint'(dvd0); b = longint'(dvs0); w = W0;
            b_ = busy0; d_ = done0; q_ = longint'(quo0); rm = longint'(rem0); z_ = dbz0;
        end else begin
            r = rst1; s = start1; a = longint'(dvd1); b = longint'(dvs1); w = W1;
            b_ = busy1; d_ = done1; q_ = longint'(quo1); rm = longint'(rem1); z_ = dbz1;
        end
        if (r) begin
            armed[k] = 1; pend[k] = 0; eb[k] = 0; ed[k] = 0;
            eq[k] = 0; er[k] = 0; ez[k] = 0;
        end else begin
            ed[k] = 0;
            if (!pend[k] && s) begin
                pend[k]    = 1;
                eb[k]      = 1;
                done_at[k] = cyc + ((b == 0) ? 1 : w + 1);
                pz[k]      = (b == 0);
                pq[k]      = (b == 0) ? ((longint'(1) << w) - 1) : a / b;
                pr[k]      = (b == 0) ? 0 : a % b;
            end else if (pend[k] && cyc == done_at[k]) begin
                pend[k] = 0; eb[k] = 0; ed[k] = 1;
                eq[k] = pq[k]; er[k] = pr[k]; ez[k] = pz[k];
            end
        end
        if (armed[k]) begin
            check($sformatf("u%0d busy", k), longint'(b_), longint'(eb[k]));
            check($sformatf("u%0d done", k), longint'(d_), longint'(ed[k]));
            check($sformatf("u%0d quotient", k), q_, eq[k]);
            check($sformatf("u%0d remainder", k), rm, er[k]);
            check($sformatf("u%0d div_by_zero", k), longint'(z_), longint'(ez[k]));
        end
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) model_step(k);
    end

    // Waits (bounded) for done; n = cycles after the accept edge, nb = cycles busy seen.
    task automatic wait_done(input int k, output int n, output int nb);
        n = 0; nb = 0;
        while (!((k == 0) ? done0 : done1) && n < 60) begin
            if ((k == 0) ? busy0 : busy1) nb++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_div(input int k, input longint a, input longint b,
                           input longint xq, input longint xr, input longint xz, input int lat);
        int n, nb;
        @(negedge clk);
        if (k == 0) begin start0 = 1; dvd0 = W0'(a); dvs0 = D0'(b); end
        else        begin start1 = 1; dvd1 = W1'(a); dvs1 = D1'(b); end
        @(negedge clk);
        if (k == 0) begin start0 = 0; dvd0 = W0'($urandom); dvs0 = D0'($urandom); end
        else        begin start1 = 0; dvd1 = W1'($urandom); dvs1 = D1'($urandom); end
        wait_done(k, n, nb);
        check($sformatf("u%0d %0d/%0d latency", k, a, b), longint'(n), longint'(lat));
        check($sformatf("u%0d %0d/%0d busy cycles", k, a, b), longint'(nb), longint'(lat));
        check($sformatf("u%0d %0d/%0d busy at done", k, a, b),
              longint'((k == 0) ? busy0 : busy1), 0);
        check($sformatf("u%0d %0d/%0d q", k, a, b),
              (k == 0) ? longint'(quo0) : longint'(quo1), xq);
        check($sformatf("u%0d %0d/%0d r", k, a, b),
              (k == 0) ? longint'(rem0) : longint'(rem1), xr);
        check($sformatf("u%0d %0d/%0d dbz", k, a, b),
              (k == 0) ? longint'(dbz0) : longint'(dbz1), xz);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nb, dones;
        rst0 = 1; rst1 = 1; start0 = 0; start1 = 0;
        dvd0 = '0; dvs0 = '0; dvd1 = '0; dvs1 = '0;
        repeat (2) @(negedge clk);
        check("reset busy", longint'(busy0), 0);
        check("reset done", longint'(done0), 0);
        check("reset quotient", longint'(quo0), 0);
        check("reset remainder", longint'(rem0), 0);
        check("reset dbz", longint'(dbz0), 0);
        rst0 = 0; rst1 = 0;

        run_div(0, 1234, 10, 123, 4, 0, 15);
        run_div(0, 16383, 10, 1638, 3, 0, 15);
        run_div(0, 9, 10, 0, 9, 0, 15);
        run_div(0, 0, 1, 0, 0, 0, 15);
        run_div(0, 500, 0, 16383, 0, 1, 1);

        // Back-to-back: a mid-run start is dropped, a held start is taken as done falls.
        @(negedge clk); start0 = 1; dvd0 = 100; dvs0 = 7;
        @(negedge clk); start0 = 0;
        repeat (4) @(negedge clk);
        start0 = 1; dvd0 = 50; dvs0 = 3;
        @(negedge clk); start0 = 0; dvd0 = 0; dvs0 = 0;
        @(negedge clk); start0 = 1; dvd0 = 50; dvs0 = 3;
        wait_done(0, n, nb);
        check("b2b first q", longint'(quo0), 14);
        check("b2b first r", longint'(rem0), 2);
        @(negedge clk); start0 = 0;
        check("b2b second accepted", longint'(busy0), 1);
        wait_done(0, n, nb);
        check("b2b second latency", longint'(n), 15);
        check("b2b second q", longint'(quo0), 16);
        check("b2b second r", longint'(rem0), 2);

        // Reset in the middle of 999/10.
        @(negedge clk); start0 = 1; dvd0 = 999; dvs0 = 10;
        @(negedge clk); start0 = 0;
        repeat (6) @(negedge clk);
        rst0 = 1;
        #1;
        check("abort busy", longint'(busy0), 0);
        check("abort done", longint'(done0), 0);
        check("abort quotient", longint'(quo0), 0);
        check("abort remainder", longint'(rem0), 0);
        @(negedge clk);
        @(negedge clk); rst0 = 0;
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (done0) dones++;
        end
        check("abort no done", longint'(dones), 0);
        run_div(0, 999, 10, 99, 9, 0, 15);

        run_div(1, 255, 255, 1, 0, 0, 9);
        run_div(1, 200, 201, 0, 200, 0, 9);
        run_div(1, 77, 0, 255, 0, 1, 1);

        fork
            begin
                for (int i = 0; i < 1500; i++) begin
                    @(negedge clk);
                    rst0   = ($urandom_range(0, 299) == 0);
                    start0 = ($urandom_range(0, 2) == 0);
                    dvd0   = W0'($urandom);
                    dvs0   = ($urandom_range(0, 7) == 0) ? '0 : D0'($urandom);
                end
                @(negedge clk); rst0 = 0; start0 = 0;
            end
            begin
                for (int j = 0; j < 1500; j++) begin
                    @(negedge clk);
                    start1 = ($urandom_range(0, 2) == 0);
                    dvd1   = W1'($urandom);
                    dvs1   = ($urandom_range(0, 7) == 0) ? '0 : D1'($urandom);
                end
                @(negedge clk); start1 = 0;
            end
        join
        repeat (30) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
